grid_renderer: RTL

//  Parametrised playfield renderer for the VGA path. Draws a ROWS x COLS grid of cells, each with a

---
 rtl/grid_pkg.sv | 27 ++
 rtl/grid_renderer_axis_tracker.sv | 66 ++++++
 rtl/grid_renderer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared colours, palette and geometry helpers for the grid renderer
package grid_pkg;

    localparam logic [11:0] EMPTY_COLOR = 12'h111;
    localparam logic [11:0] GRID_COLOR  = 12'h222;
    localparam logic [11:0] FLASH_COLOR = 12'hFFF;

    localparam int PAL_BITS  = 3;
    localparam int PALETTE_N = 2 ** PAL_BITS;

    localparam logic [11:0] PALETTE [0:PALETTE_N-1] = '{
        12'h000, 12'hF00, 12'h0F0, 12'h00F,
        12'hFF0, 12'hF0F, 12'h0FF, 12'hF80
    };

    function automatic int pitch_w(input int block_size, input int gap);
        return $clog2(block_size + gap);
    endfunction

    // Wider cell indices alias onto the low palette bits.
    function automatic logic [11:0] palette_color(input int idx);
        logic [PAL_BITS-1:0] i;
        i = idx[PAL_BITS-1:0];
        return PALETTE[i];
    endfunction

endpackage

// File: rtl/grid_renderer_axis_tracker.sv
// rtl/grid_renderer_axis_tracker.sv - incremental cell index/offset tracker along one screen axis
module axis_tracker
    import grid_pkg::*;
#(
    parameter int COUNT      = 20,
    parameter int BLOCK_SIZE = 17,
    parameter int GAP        = 4,
    parameter int IDX_W      = $clog2(COUNT + 1),
    parameter int OFF_W      = pitch_w(BLOCK_SIZE, GAP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             clear_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [OFF_W-1:0] off_o,
    output logic             act_o
);

    localparam int PITCH = BLOCK_SIZE + GAP;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             act_q, act_d;

    always_comb begin
        idx_d = idx_q;
        off_d = off_q;
        act_d = act_q;
        if (start_i) begin
            act_d = 1'b1;
            idx_d = '0;
            off_d = '0;
        end else if (clear_i) begin
            act_d = 1'b0;
        end else if (step_i && act_q) begin
            if (off_q == OFF_W'(PITCH - 1)) begin
                off_d = '0;
                idx_d = idx_q + 1'b1;
                // Stepping past the last cell (trailing gap included) ends the run.
                if (idx_q == IDX_W'(COUNT - 1))
                    act_d = 1'b0;
            end else begin
                off_d = off_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            off_q <= '0;
            act_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            off_q <= off_d;
            act_q <= act_d;
        end
    end

    assign idx_o = idx_q;
    assign off_o = off_q;
    assign act_o = act_q;

endmodule

// File: rtl/grid_renderer.sv
// rtl/grid_renderer.sv - ROWS x COLS playfield renderer driven by the VGA beam counters
module grid_renderer
    import grid_pkg::*;
#(
    parameter int ROWS         = 20,
    parameter int COLS         = 12,
    parameter int CELL_BITS    = 3,
    parameter int COL_START    = 340,
    parameter int ROW_START    = 67,
    parameter int BLOCK_SIZE   = 17,
    parameter int GAP          = 4,
    parameter int FLASH_FRAMES = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9:0]                    counter_x,
    input  logic [9:0]                    counter_y,
    input  logic [ROWS*COLS*CELL_BITS-1:0] data,
    input  logic [ROWS-1:0]               row_flash,
    input  logic                          grid_lines_en,
    output logic [3:0]                    r_red,
    output logic [3:0]                    r_green,
    output logic [3:0]                    r_blue,
    output logic                          in_grid
);

    localparam int DATA_W = ROWS * COLS * CELL_BITS;
    localparam int SEL_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int RSEL_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int RIDX_W = $clog2(ROWS + 1);
    localparam int CIDX_W = $clog2(COLS + 1);
    localparam int OFF_W  = pitch_w(BLOCK_SIZE, GAP);
    localparam int FC_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic frame_start;
    assign frame_start = (counter_x == 10'd0) && (counter_y == 10'd0);

    logic [DATA_W-1:0] data_q;
    logic [ROWS-1:0]   row_flash_q;
    logic [FC_W-1:0]   flash_cnt_q;
    logic              flash_phase_q;

    // Cell data and flash mask are sampled once per frame so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q        <= '0;
            row_flash_q   <= '0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
        end else if (frame_start) begin
            data_q      <= data;
            row_flash_q <= row_flash;
            if (flash_cnt_q == FC_W'(FLASH_FRAMES - 1)) begin
                flash_cnt_q   <= '0;
                flash_phase_q <= ~flash_phase_q;
            end else begin
                flash_cnt_q <= flash_cnt_q + 1'b1;
            end
        end
    end

    logic [RIDX_W-1:0] row_idx;
    logic [OFF_W-1:0]  row_off;
    logic              row_act;
    logic [CIDX_W-1:0] col_idx;
    logic [OFF_W-1:0]  col_off;
    logic              col_act;

    axis_tracker #(.COUNT(ROWS), .BLOCK_SIZE(BLOCK_SIZE), .GAP(GAP)) u_row (
        .clk     (clk),
        .rst     (rst),
        .start_i ((counter_x == 10'd0) && (counter_y == 10'(ROW_START))),
        .step_i  (counter_x == 10'd0),
        .clear_i (1'b0),
        .idx_o   (row_idx),
        .off_o   (row_off),
        .act_o   (row_act)
    );

    // Start outranks the line-start clear when COL_START is 0.
    axis_tracker #(.COUNT(COLS), .BLOCK_SIZE(BLOCK_SIZE), .GAP(GAP)) u_col (
        .clk     (clk),
        .rst     (rst),
        .start_i (counter_x == 10'(COL_START)),
        .step_i  (1'b1),
        .clear_i (counter_x == 10'd0),
        .idx_o   (col_idx),
        .off_o   (col_off),
        .act_o   (col_act)
    );

    logic                 active, in_cell, trailing, gap_px, flash_px;
    logic [SEL_W-1:0]     cell_base;
    logic [RSEL_W-1:0]    row_sel;
    logic [CELL_BITS-1:0] cell_idx;
    logic [11:0]          color_d, color_q;
    logic                 in_grid_d, in_grid_q;

    always_comb begin
        active    = row_act && col_act;
        in_cell   = (row_off < OFF_W'(BLOCK_SIZE)) && (col_off < OFF_W'(BLOCK_SIZE));
        trailing  = ((col_off >= OFF_W'(BLOCK_SIZE)) && (col_idx == CIDX_W'(COLS - 1))) ||
                    ((row_off >= OFF_W'(BLOCK_SIZE)) && (row_idx == RIDX_W'(ROWS - 1)));
        gap_px    = !in_cell && !trailing;
        cell_base = SEL_W'((int'(row_idx) * COLS + int'(col_idx)) * CELL_BITS);
        row_sel   = RSEL_W'(row_idx);
        cell_idx  = data_q[cell_base +: CELL_BITS];
        flash_px  = row_flash_q[row_sel] && flash_phase_q;
        color_d   = 12'h000;
        in_grid_d = 1'b0;
        if (active && in_cell) begin
            in_grid_d = 1'b1;
            if (flash_px)
                color_d = FLASH_COLOR;
            else if (cell_idx != '0)
                color_d = palette_color(int'(cell_idx));
            else
                color_d = EMPTY_COLOR;
        end else if (active && gap_px) begin
            in_grid_d = 1'b1;
            if (grid_lines_en)
                color_d = GRID_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q   <= 12'h000;
            in_grid_q <= 1'b0;
        end else begin
            color_q   <= color_d;
            in_grid_q <= in_grid_d;
        end
    end

    assign r_red   = color_q[11:8];
    assign r_green = color_q[7:4];
    assign r_blue  = color_q[3:0];
    assign in_grid = in_grid_q;

endmodule
